// File: rtl/xo_dispatch_queue_pkg.sv
// Shared definitions for the XO dispatch path: field widths, functional-unit codes
// and the packed queue entry used by decode, dispatch and the execution units.
package xo_dispatch_queue_pkg;

    localparam int X_OP_CODE_WIDTH = 9;
    localparam int REG_WIDTH       = 5;
    localparam int FUNIT_WIDTH     = 3;
    localparam int NUM_UNITS       = 5;
    localparam int DEPTH           = 4;
    localparam int PTR_WIDTH       = 2;

    localparam logic [FUNIT_WIDTH-1:0] FU_FX     = 3'd0;
    localparam logic [FUNIT_WIDTH-1:0] FU_FP     = 3'd1;
    localparam logic [FUNIT_WIDTH-1:0] FU_LD_ST  = 3'd2;
    localparam logic [FUNIT_WIDTH-1:0] FU_BRANCH = 3'd3;
    localparam logic [FUNIT_WIDTH-1:0] FU_TRAP   = 3'd4;

    typedef struct packed {
        logic [REG_WIDTH-1:0]       reg1;
        logic [REG_WIDTH-1:0]       reg2;
        logic [REG_WIDTH-1:0]       reg3;
        logic [X_OP_CODE_WIDTH-1:0] x_op_code;
        logic                       bit1;
        logic                       bit2;
        logic [FUNIT_WIDTH-1:0]     funit;
    } xo_entry_t;

    function automatic logic unit_is_legal(input logic [FUNIT_WIDTH-1:0] code);
        return code < FUNIT_WIDTH'(NUM_UNITS);
    endfunction

endpackage

// File: rtl/xo_dispatch_queue_if.sv
// Decode-side and dispatch-side signals of the XO dispatch queue.
// master = decode/issue environment, slave = the queue itself.
interface xo_dispatch_queue_if;
    import xo_dispatch_queue_pkg::*;

    logic                       flush_i;
    logic                       enable_i;
    logic [REG_WIDTH-1:0]       reg1_i;
    logic [REG_WIDTH-1:0]       reg2_i;
    logic [REG_WIDTH-1:0]       reg3_i;
    logic [X_OP_CODE_WIDTH-1:0] xOpCode_i;
    logic                       bit1_i;
    logic                       bit2_i;
    logic [FUNIT_WIDTH-1:0]     functionalUnitCode_i;
    logic [NUM_UNITS-1:0]       unitReady_i;

    logic                       stall_o;
    logic [PTR_WIDTH:0]         count_o;
    logic [REG_WIDTH-1:0]       reg1_o;
    logic [REG_WIDTH-1:0]       reg2_o;
    logic [REG_WIDTH-1:0]       reg3_o;
    logic [X_OP_CODE_WIDTH-1:0] xOpCode_o;
    logic                       bit1_o;
    logic                       bit2_o;
    logic [FUNIT_WIDTH-1:0]     functionalUnitCode_o;
    logic                       enable_o;
    logic                       overflow_o;
    logic                       badUnit_o;

    modport master (
        output flush_i, enable_i, reg1_i, reg2_i, reg3_i, xOpCode_i, bit1_i, bit2_i,
               functionalUnitCode_i, unitReady_i,
        input  stall_o, count_o, reg1_o, reg2_o, reg3_o, xOpCode_o, bit1_o, bit2_o,
               functionalUnitCode_o, enable_o, overflow_o, badUnit_o
    );

    modport slave (
        input  flush_i, enable_i, reg1_i, reg2_i, reg3_i, xOpCode_i, bit1_i, bit2_i,
               functionalUnitCode_i, unitReady_i,
        output stall_o, count_o, reg1_o, reg2_o, reg3_o, xOpCode_o, bit1_o, bit2_o,
               functionalUnitCode_o, enable_o, overflow_o, badUnit_o
    );

endinterface

// File: rtl/xo_sync_fifo.sv
// Generic synchronous FIFO storage with wrapping pointers and an explicit count.
// The caller guarantees no write when full without a read, and no read when empty.
module xo_sync_fifo #(
    parameter int WIDTH = 29,
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [PTR_W:0]   count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (wr_en && !clear) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/xo_dispatch_queue.sv
// In-order dispatch buffer behind the XO decoder: queues decoded instructions and
// issues the head to its functional unit once that unit is ready.
module xo_dispatch_queue
    import xo_dispatch_queue_pkg::*;
(
    input  logic               clock_i,
    input  logic               reset_i,
    xo_dispatch_queue_if.slave bus
);

    localparam int ENTRY_WIDTH = $bits(xo_entry_t);
    localparam logic [PTR_WIDTH:0] FULL_COUNT = (PTR_WIDTH + 1)'(DEPTH);

    xo_entry_t            wr_entry;
    xo_entry_t            head;
    xo_entry_t            out_q;
    logic [PTR_WIDTH:0]   count;
    logic [7:0]           ready_ext;
    logic                 not_empty;
    logic                 full;
    logic                 pop;
    logic                 discard;
    logic                 wr_en;
    logic                 enable_q;
    logic                 bad_unit_q;
    logic                 overflow_q;

    assign wr_entry = '{
        reg1:      bus.reg1_i,
        reg2:      bus.reg2_i,
        reg3:      bus.reg3_i,
        x_op_code: bus.xOpCode_i,
        bit1:      bus.bit1_i,
        bit2:      bus.bit2_i,
        funit:     bus.functionalUnitCode_i
    };

    // Zero-extended so an illegal head code can never index past the ready vector.
    assign ready_ext = {{(8 - NUM_UNITS){1'b0}}, bus.unitReady_i};
    assign not_empty = (count != '0);
    assign full      = (count == FULL_COUNT);
    assign pop       = not_empty && unit_is_legal(head.funit) && ready_ext[head.funit];
    assign discard   = not_empty && !unit_is_legal(head.funit);
    assign wr_en     = bus.enable_i && (!full || pop || discard);

    xo_sync_fifo #(
        .WIDTH (ENTRY_WIDTH),
        .DEPTH (DEPTH),
        .PTR_W (PTR_WIDTH)
    ) u_fifo (
        .clk     (clock_i),
        .clear   (reset_i || bus.flush_i),
        .wr_en   (wr_en),
        .wr_data (wr_entry),
        .rd_en   (pop || discard),
        .rd_data (head),
        .count   (count)
    );

    // Flush clears the handshake and sticky flags but leaves the last dispatched fields.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            out_q      <= '0;
            enable_q   <= 1'b0;
            bad_unit_q <= 1'b0;
            overflow_q <= 1'b0;
        end else if (bus.flush_i) begin
            enable_q   <= 1'b0;
            bad_unit_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            enable_q   <= pop;
            bad_unit_q <= discard;
            if (pop) begin
                out_q <= head;
            end
            if (bus.enable_i && !wr_en) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign bus.stall_o              = full;
    assign bus.count_o              = count;
    assign bus.reg1_o               = out_q.reg1;
    assign bus.reg2_o               = out_q.reg2;
    assign bus.reg3_o               = out_q.reg3;
    assign bus.xOpCode_o            = out_q.x_op_code;
    assign bus.bit1_o               = out_q.bit1;
    assign bus.bit2_o               = out_q.bit2;
    assign bus.functionalUnitCode_o = out_q.funit;
    assign bus.enable_o             = enable_q;
    assign bus.overflow_o           = overflow_q;
    assign bus.badUnit_o            = bad_unit_q;

endmodule

// File: tb/tb_xo_dispatch_queue.sv
// Directed bench for xo_dispatch_queue with hand-computed expectations per scenario.
module tb_xo_dispatch_queue;
    import xo_dispatch_queue_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    xo_dispatch_queue_if bus ();

    xo_dispatch_queue dut (
        .clock_i (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_entry(input int r1, input int r2, input int r3, input int xop,
                             input logic b1, input logic b2, input logic [2:0] fu);
        bus.enable_i             = 1'b1;
        bus.reg1_i               = 5'(r1);
        bus.reg2_i               = 5'(r2);
        bus.reg3_i               = 5'(r3);
        bus.xOpCode_i            = 9'(xop);
        bus.bit1_i               = b1;
        bus.bit2_i               = b2;
        bus.functionalUnitCode_i = fu;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (bus.count_o !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", bus.count_o); end
        checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", bus.stall_o); end
        checks++; if (bus.enable_o !== 1'b0) begin errors++; $display("FAIL reset_enable got %b want 0", bus.enable_o); end
        checks++; if (bus.overflow_o !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", bus.overflow_o); end
        checks++; if (bus.badUnit_o !== 1'b0) begin errors++; $display("FAIL reset_badunit got %b want 0", bus.badUnit_o); end
        checks++; if (bus.xOpCode_o !== 9'd0 || bus.reg1_o !== 5'd0) begin errors++; $display("FAIL reset_data got xop=%0d reg1=%0d want 0 0", bus.xOpCode_o, bus.reg1_o); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        bus.unitReady_i = 5'b11111;
        set_entry(3, 4, 5, 266, 1'b1, 1'b0, FU_FX);
        tick();
        bus.enable_i = 1'b0;
        checks++; if (bus.enable_o !== 1'b0) begin errors++; $display("FAIL single_no_bypass got %b want 0", bus.enable_o); end
        checks++; if (bus.count_o !== 3'd1) begin errors++; $display("FAIL single_count1 got %0d want 1", bus.count_o); end
        tick();
        checks++; if (bus.enable_o !== 1'b1) begin errors++; $display("FAIL single_enable got %b want 1", bus.enable_o); end
        checks++;
        if (bus.reg1_o !== 5'd3 || bus.reg2_o !== 5'd4 || bus.reg3_o !== 5'd5 || bus.xOpCode_o !== 9'd266 ||
            bus.bit1_o !== 1'b1 || bus.bit2_o !== 1'b0 || bus.functionalUnitCode_o !== FU_FX) begin
            errors++;
            $display("FAIL single_fields got %0d/%0d/%0d xop=%0d b=%b%b fu=%0d want 3/4/5 xop=266 b=10 fu=0",
                     bus.reg1_o, bus.reg2_o, bus.reg3_o, bus.xOpCode_o, bus.bit1_o, bus.bit2_o, bus.functionalUnitCode_o);
        end
        checks++; if (bus.count_o !== 3'd0) begin errors++; $display("FAIL single_count0 got %0d want 0", bus.count_o); end
        tick();
        checks++; if (bus.enable_o !== 1'b0) begin errors++; $display("FAIL single_pulse got %b want 0", bus.enable_o); end
    endtask

    task automatic test_fill();
        int xops [4];
        xops = '{266, 40, 10, 8};
        bus.unitReady_i = 5'b00000;
        for (int i = 0; i < 4; i++) begin
            set_entry(i + 1, i + 2, i + 3, xops[i], 1'b0, 1'b1, FU_FX);
            tick();
        end
        checks++; if (bus.count_o !== 3'd4) begin errors++; $display("FAIL fill_count got %0d want 4", bus.count_o); end
        checks++; if (bus.stall_o !== 1'b1) begin errors++; $display("FAIL fill_stall got %b want 1", bus.stall_o); end
        checks++; if (bus.overflow_o !== 1'b0) begin errors++; $display("FAIL fill_no_overflow got %b want 0", bus.overflow_o); end
        set_entry(9, 9, 9, 138, 1'b0, 1'b0, FU_FX);
        tick();
        bus.enable_i = 1'b0;
        checks++; if (bus.overflow_o !== 1'b1) begin errors++; $display("FAIL fill_overflow got %b want 1", bus.overflow_o); end
        checks++; if (bus.count_o !== 3'd4) begin errors++; $display("FAIL fill_count_after_drop got %0d want 4", bus.count_o); end
        bus.unitReady_i = 5'b11111;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (bus.enable_o !== 1'b1 || bus.xOpCode_o !== 9'(xops[i])) begin
                errors++;
                $display("FAIL fill_drain%0d got en=%b xop=%0d want en=1 xop=%0d", i, bus.enable_o, bus.xOpCode_o, xops[i]);
            end
        end
        tick();
        checks++; if (bus.enable_o !== 1'b0) begin errors++; $display("FAIL fill_drained_enable got %b want 0", bus.enable_o); end
        checks++; if (bus.count_o !== 3'd0 || bus.stall_o !== 1'b0) begin errors++; $display("FAIL fill_drained_count got %0d stall=%b want 0 0", bus.count_o, bus.stall_o); end
        checks++; if (bus.overflow_o !== 1'b1) begin errors++; $display("FAIL fill_overflow_sticky got %b want 1", bus.overflow_o); end
    endtask

    task automatic test_hol();
        bus.unitReady_i = 5'b10000;
        set_entry(1, 1, 1, 31, 1'b0, 1'b0, FU_FP);
        tick();
        set_entry(2, 2, 2, 32, 1'b0, 1'b0, FU_FX);
        tick();
        bus.enable_i = 1'b0;
        tick();
        checks++; if (bus.enable_o !== 1'b0 || bus.count_o !== 3'd2) begin errors++; $display("FAIL hol_blocked got en=%b count=%0d want 0 2", bus.enable_o, bus.count_o); end
        bus.unitReady_i = 5'b10001;
        tick();
        checks++; if (bus.enable_o !== 1'b0 || bus.count_o !== 3'd2) begin errors++; $display("FAIL hol_in_order got en=%b count=%0d want 0 2", bus.enable_o, bus.count_o); end
        bus.unitReady_i = 5'b10011;
        tick();
        checks++;
        if (bus.enable_o !== 1'b1 || bus.functionalUnitCode_o !== FU_FP || bus.xOpCode_o !== 9'd31) begin
            errors++; $display("FAIL hol_first got en=%b fu=%0d xop=%0d want 1 1 31", bus.enable_o, bus.functionalUnitCode_o, bus.xOpCode_o);
        end
        tick();
        checks++;
        if (bus.enable_o !== 1'b1 || bus.functionalUnitCode_o !== FU_FX || bus.xOpCode_o !== 9'd32) begin
            errors++; $display("FAIL hol_second got en=%b fu=%0d xop=%0d want 1 0 32", bus.enable_o, bus.functionalUnitCode_o, bus.xOpCode_o);
        end
        checks++; if (bus.count_o !== 3'd0) begin errors++; $display("FAIL hol_count got %0d want 0", bus.count_o); end
        tick();
    endtask

    task automatic test_bad_unit();
        bus.unitReady_i = 5'b11111;
        set_entry(7, 7, 7, 77, 1'b0, 1'b0, 3'd6);
        tick();
        set_entry(8, 8, 8, 78, 1'b1, 1'b1, FU_FX);
        tick();
        bus.enable_i = 1'b0;
        checks++; if (bus.badUnit_o !== 1'b1 || bus.enable_o !== 1'b0) begin errors++; $display("FAIL bad_discard got bad=%b en=%b want 1 0", bus.badUnit_o, bus.enable_o); end
        checks++; if (bus.count_o !== 3'd1) begin errors++; $display("FAIL bad_count got %0d want 1", bus.count_o); end
        tick();
        checks++;
        if (bus.enable_o !== 1'b1 || bus.xOpCode_o !== 9'd78 || bus.badUnit_o !== 1'b0) begin
            errors++; $display("FAIL bad_next got en=%b xop=%0d bad=%b want 1 78 0", bus.enable_o, bus.xOpCode_o, bus.badUnit_o);
        end
        tick();
    endtask

    task automatic test_flush();
        bus.unitReady_i = 5'b00000;
        for (int i = 0; i < 3; i++) begin
            set_entry(i, i, i, 50 + i, 1'b0, 1'b0, FU_BRANCH);
            tick();
        end
        set_entry(4, 4, 4, 53, 1'b0, 1'b0, FU_BRANCH);
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i  = 1'b0;
        bus.enable_i = 1'b0;
        checks++; if (bus.count_o !== 3'd0 || bus.stall_o !== 1'b0) begin errors++; $display("FAIL flush_count got %0d stall=%b want 0 0", bus.count_o, bus.stall_o); end
        checks++; if (bus.overflow_o !== 1'b0 || bus.enable_o !== 1'b0) begin errors++; $display("FAIL flush_flags got ovf=%b en=%b want 0 0", bus.overflow_o, bus.enable_o); end
        checks++; if (bus.xOpCode_o !== 9'd78 || bus.reg1_o !== 5'd8) begin errors++; $display("FAIL flush_data_hold got xop=%0d reg1=%0d want 78 8", bus.xOpCode_o, bus.reg1_o); end
        bus.unitReady_i = 5'b11111;
        tick();
        checks++; if (bus.enable_o !== 1'b0 || bus.count_o !== 3'd0) begin errors++; $display("FAIL flush_dropped got en=%b count=%0d want 0 0", bus.enable_o, bus.count_o); end
    endtask

    task automatic test_reset_mid();
        bus.unitReady_i = 5'b00000;
        for (int i = 0; i < 5; i++) begin
            set_entry(i + 1, i + 1, i + 1, 60 + i, 1'b1, 1'b1, FU_TRAP);
            tick();
        end
        checks++; if (bus.overflow_o !== 1'b1) begin errors++; $display("FAIL rstmid_overflow got %b want 1", bus.overflow_o); end
        set_entry(6, 6, 6, 65, 1'b0, 1'b0, FU_LD_ST);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.enable_i = 1'b0;
        checks++;
        if (bus.count_o !== 3'd0 || bus.stall_o !== 1'b0 || bus.overflow_o !== 1'b0 || bus.enable_o !== 1'b0 || bus.badUnit_o !== 1'b0) begin
            errors++; $display("FAIL rstmid_ctrl got count=%0d stall=%b ovf=%b en=%b bad=%b want all 0",
                                bus.count_o, bus.stall_o, bus.overflow_o, bus.enable_o, bus.badUnit_o);
        end
        checks++;
        if (bus.xOpCode_o !== 9'd0 || bus.reg1_o !== 5'd0 || bus.reg2_o !== 5'd0 || bus.reg3_o !== 5'd0 ||
            bus.bit1_o !== 1'b0 || bus.bit2_o !== 1'b0 || bus.functionalUnitCode_o !== 3'd0) begin
            errors++; $display("FAIL rstmid_data got xop=%0d reg1=%0d want all 0", bus.xOpCode_o, bus.reg1_o);
        end
        bus.unitReady_i = 5'b11111;
        tick();
        checks++; if (bus.enable_o !== 1'b0) begin errors++; $display("FAIL rstmid_empty got en=%b want 0", bus.enable_o); end
    endtask

    task automatic test_full_pop();
        bus.unitReady_i = 5'b00000;
        for (int i = 1; i <= 4; i++) begin
            set_entry(i, i, i, i, 1'b0, 1'b0, FU_FX);
            tick();
        end
        checks++; if (bus.count_o !== 3'd4) begin errors++; $display("FAIL fullpop_fill got %0d want 4", bus.count_o); end
        bus.unitReady_i = 5'b11111;
        set_entry(5, 5, 5, 5, 1'b0, 1'b0, FU_FX);
        tick();
        bus.enable_i = 1'b0;
        checks++; if (bus.enable_o !== 1'b1 || bus.xOpCode_o !== 9'd1) begin errors++; $display("FAIL fullpop_dispatch got en=%b xop=%0d want 1 1", bus.enable_o, bus.xOpCode_o); end
        checks++; if (bus.count_o !== 3'd4 || bus.overflow_o !== 1'b0) begin errors++; $display("FAIL fullpop_count got count=%0d ovf=%b want 4 0", bus.count_o, bus.overflow_o); end
        for (int i = 2; i <= 5; i++) begin
            tick();
            checks++;
            if (bus.enable_o !== 1'b1 || bus.xOpCode_o !== 9'(i)) begin
                errors++; $display("FAIL fullpop_drain%0d got en=%b xop=%0d want 1 %0d", i, bus.enable_o, bus.xOpCode_o, i);
            end
        end
        tick();
        checks++; if (bus.enable_o !== 1'b0 || bus.count_o !== 3'd0) begin errors++; $display("FAIL fullpop_empty got en=%b count=%0d want 0 0", bus.enable_o, bus.count_o); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.flush_i = 1'b0;
        bus.enable_i = 1'b0;
        bus.reg1_i = '0;
        bus.reg2_i = '0;
        bus.reg3_i = '0;
        bus.xOpCode_i = '0;
        bus.bit1_i = 1'b0;
        bus.bit2_i = 1'b0;
        bus.functionalUnitCode_i = '0;
        bus.unitReady_i = '0;

        test_reset();
        test_single();
        test_fill();
        test_hol();
        test_bad_unit();
        test_flush();
        test_reset_mid();
        test_full_pop();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
